// File: rtl/tb_irq_timer_periph.sv
// Memory-mapped interrupt/timer pseudo-peripheral for the core testbench.
// Drives the core's exploded irq lines; clears pending sources on irq_ack/irq_id.
module tb_irq_timer_periph #(
  parameter int unsigned NUM_FAST_IRQ   = 15,
  parameter int unsigned TIMER_WIDTH    = 32,
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter int unsigned DELAY_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [11:0]             addr_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  input  logic                    irq_ack_i,
  input  logic [4:0]              irq_id_i,
  output logic                    irq_software_o,
  output logic                    irq_timer_o,
  output logic                    irq_external_o,
  output logic [NUM_FAST_IRQ-1:0] irq_fast_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NF     = NUM_FAST_IRQ;
  localparam int unsigned TW     = TIMER_WIDTH;
  localparam int unsigned PW     = PRESCALE_WIDTH;
  localparam int unsigned DW     = DELAY_WIDTH;

  localparam logic [11:0] OFF_TIMER  = 12'h000;
  localparam logic [11:0] OFF_CMP    = 12'h004;
  localparam logic [11:0] OFF_CTRL   = 12'h008;
  localparam logic [11:0] OFF_PRE    = 12'h00C;
  localparam logic [11:0] OFF_SW     = 12'h010;
  localparam logic [11:0] OFF_EXT    = 12'h014;
  localparam logic [11:0] OFF_FSET   = 12'h018;
  localparam logic [11:0] OFF_FCLR   = 12'h01C;
  localparam logic [11:0] OFF_DMASK  = 12'h020;
  localparam logic [11:0] OFF_DCNT   = 12'h024;
  localparam logic [11:0] OFF_STATUS = 12'h028;

  logic [TW-1:0]     timer_q, timer_d, cmp_q, cmp_d;
  logic [PW-1:0]     pre_q, pre_d, pcnt_q, pcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [NF-1:0]     fast_q, fast_d, mask_q, mask_d;
  logic              en_q, en_d, per_q, per_d;
  logic              sw_q, sw_d, ext_q, ext_d, tp_q, tp_d, armed_q, armed_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_val, be_mask;
  logic [NF-1:0]     ack_fast, fast_set, fast_clr;
  logic              wr, tick, match, inject;

  // Byte-enable merge of the write data into an existing register value
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] d,
                                              input logic [DATA_W-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign gnt_o = req_i;
  assign wr    = req_i & we_i;
  assign be_mask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  always_comb begin
    rd_val = '0;
    case (addr_i)
      OFF_TIMER:          rd_val = DATA_W'(timer_q);
      OFF_CMP:            rd_val = DATA_W'(cmp_q);
      OFF_CTRL:           rd_val = {30'b0, per_q, en_q};
      OFF_PRE:            rd_val = DATA_W'(pre_q);
      OFF_SW:             rd_val = {31'b0, sw_q};
      OFF_EXT:            rd_val = {31'b0, ext_q};
      OFF_FSET, OFF_FCLR: rd_val = DATA_W'(fast_q);
      OFF_DMASK:          rd_val = DATA_W'(mask_q);
      OFF_DCNT:           rd_val = DATA_W'(dcnt_q);
      OFF_STATUS:         rd_val = {30'b0, armed_q, tp_q};
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    ack_fast = '0;
    for (int unsigned k = 0; k < NF; k++) begin
      ack_fast[k] = irq_ack_i && (irq_id_i == 5'(16 + k));
    end
  end

  // Next-state: timer, delayed injection, pending sources and bus response
  always_comb begin
    rdata_d = (req_i && !we_i) ? rd_val : '0;

    tick   = en_q && (pcnt_q >= pre_q);
    match  = tick && (timer_q == cmp_q);
    inject = armed_q && (dcnt_q == '0);

    pcnt_d = pcnt_q;
    if (en_q) pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    pre_d = pre_q;
    if (wr && addr_i == OFF_PRE) pre_d = PW'(merge(DATA_W'(pre_q), wdata_i, be_mask));

    timer_d = timer_q;
    if (tick) timer_d = (match && per_q) ? '0 : timer_q + TW'(1);
    if (wr && addr_i == OFF_TIMER) timer_d = TW'(merge(DATA_W'(timer_q), wdata_i, be_mask));

    cmp_d = cmp_q;
    if (wr && addr_i == OFF_CMP) cmp_d = TW'(merge(DATA_W'(cmp_q), wdata_i, be_mask));

    // Match (set) wins over a CMP write or ack (clear) in the same cycle
    tp_d = tp_q;
    if ((wr && addr_i == OFF_CMP) || (irq_ack_i && irq_id_i == 5'd7)) tp_d = 1'b0;
    if (match) tp_d = 1'b1;

    en_d  = en_q;
    per_d = per_q;
    if (wr && addr_i == OFF_CTRL && be_i[0]) begin
      en_d  = wdata_i[0];
      per_d = wdata_i[1];
    end

    sw_d = sw_q;
    if (irq_ack_i && irq_id_i == 5'd3) sw_d = 1'b0;
    if (wr && addr_i == OFF_SW && be_i[0]) sw_d = wdata_i[0];

    ext_d = ext_q;
    if (irq_ack_i && irq_id_i == 5'd11) ext_d = 1'b0;
    if (wr && addr_i == OFF_EXT && be_i[0]) ext_d = wdata_i[0];

    mask_d = mask_q;
    if (wr && addr_i == OFF_DMASK) mask_d = NF'(merge(DATA_W'(mask_q), wdata_i, be_mask));

    dcnt_d  = dcnt_q;
    armed_d = armed_q;
    if (armed_q) begin
      if (inject) armed_d = 1'b0;
      else        dcnt_d  = dcnt_q - DW'(1);
    end
    if (wr && addr_i == OFF_DCNT) begin
      dcnt_d  = DW'(merge(DATA_W'(dcnt_q), wdata_i, be_mask));
      armed_d = (dcnt_d != '0);
    end

    fast_set = (wr && addr_i == OFF_FSET) ? NF'(wdata_i & be_mask) : '0;
    fast_clr = (wr && addr_i == OFF_FCLR) ? NF'(wdata_i & be_mask) : '0;
    fast_d   = (fast_q & ~(fast_clr | ack_fast)) | fast_set | (inject ? mask_q : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q  <= '0;
      cmp_q    <= '0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
      fast_q   <= '0;
      mask_q   <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      sw_q     <= 1'b0;
      ext_q    <= 1'b0;
      tp_q     <= 1'b0;
      armed_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      dcnt_q   <= dcnt_d;
      fast_q   <= fast_d;
      mask_q   <= mask_d;
      en_q     <= en_d;
      per_q    <= per_d;
      sw_q     <= sw_d;
      ext_q    <= ext_d;
      tp_q     <= tp_d;
      armed_q  <= armed_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign irq_software_o = sw_q;
  assign irq_timer_o    = tp_q;
  assign irq_external_o = ext_q;
  assign irq_fast_o     = fast_q;

endmodule
